// File: rtl/noc_ram_pkg.sv
// Shared definitions for the NoC RAM requester: FSM states and the bit
// offsets of the request and response fields inside the packed words.
package noc_ram_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN,
        DONE
    } req_state_t;

    // Request word, MSB-first: {data, addr, write_en, read_en, src}
    localparam int REQ_SRC_LSB = 0;

    function automatic int req_re_bit(input int n_addr_w);
        return n_addr_w;
    endfunction

    function automatic int req_we_bit(input int n_addr_w);
        return n_addr_w + 1;
    endfunction

    function automatic int req_addr_lsb(input int n_addr_w);
        return n_addr_w + 2;
    endfunction

    function automatic int req_data_lsb(input int addr_w, input int n_addr_w);
        return addr_w + n_addr_w + 2;
    endfunction

    // Response word, MSB-first: {data, src_node}
    localparam int RSP_SRC_LSB = 0;

    function automatic int rsp_data_lsb(input int n_addr_w);
        return n_addr_w;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with first-word fall-through read data.
// Push and pop may happen together in any fill state; a pop on an empty
// FIFO is ignored, and a push on a full FIFO is accepted only alongside a pop.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage array, data only, no reset needed
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ram_requester.sv
// NoC RAM self-test requester: writes a seeded pattern to a block of RAM
// words, reads it back with a bounded number of reads in flight, and
// checks every response against the address it was issued for.
module ram_requester
    import noc_ram_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int ADDR_WIDTH      = 4,
    parameter int N               = 16,
    parameter int N_ADDR_WIDTH    = $clog2(N),
    parameter int NODE            = 0,
    parameter int RAM_NODE        = 15,
    parameter int BASE_ADDR       = 0,
    parameter int NUM_WORDS       = 8,
    parameter int SEED            = 8'h5A,
    parameter int MAX_OUTSTANDING = 4,
    localparam int REQ_W          = WIDTH + ADDR_WIDTH + 2 + N_ADDR_WIDTH,
    localparam int RSP_W          = WIDTH + N_ADDR_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic [REQ_W-1:0]        o_packed_out,
    output logic [N_ADDR_WIDTH-1:0] o_dest_out,
    output logic                    o_valid_out,
    input  logic                    o_ready_in,
    input  logic [RSP_W-1:0]        i_packed_in,
    input  logic                    i_valid_in,
    output logic                    i_ready_out,
    output logic                    done,
    output logic                    pass,
    output logic [7:0]              err_count,
    output logic [7:0]              rd_count
);

    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

    localparam int REQ_RE_BIT   = req_re_bit(N_ADDR_WIDTH);
    localparam int REQ_WE_BIT   = req_we_bit(N_ADDR_WIDTH);
    localparam int REQ_ADDR_LSB = req_addr_lsb(N_ADDR_WIDTH);
    localparam int REQ_DATA_LSB = req_data_lsb(ADDR_WIDTH, N_ADDR_WIDTH);
    localparam int RSP_DATA_LSB = rsp_data_lsb(N_ADDR_WIDTH);

    localparam logic [ADDR_WIDTH-1:0]   BASE_A = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [WIDTH-1:0]        SEED_W = WIDTH'(SEED);
    localparam logic [N_ADDR_WIDTH-1:0] SRC_ID = N_ADDR_WIDTH'(NODE);
    localparam logic [N_ADDR_WIDTH-1:0] RAM_ID = N_ADDR_WIDTH'(RAM_NODE);

    req_state_t            state;
    logic [IDX_W-1:0]      idx;
    logic [OUT_W-1:0]      outstanding;
    logic [OUT_W-1:0]      outstanding_nxt;
    logic                  xfer;
    logic                  last_idx;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  have_out;
    logic [ADDR_WIDTH-1:0] exp_addr;
    logic [WIDTH-1:0]      rsp_data;
    logic [N_ADDR_WIDTH-1:0] rsp_src;
    logic                  rsp_bad;
    logic                  rsp_err;
    logic [7:0]            err_nxt;
    logic [7:0]            rd_nxt;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] addr_of(input logic [IDX_W-1:0] i);
        return BASE_A + ADDR_WIDTH'(i);
    endfunction

    function automatic logic [WIDTH-1:0] data_of(input logic [ADDR_WIDTH-1:0] a);
        return WIDTH'(a) + SEED_W;
    endfunction

    function automatic logic [REQ_W-1:0] pack_req(input logic we, input logic [ADDR_WIDTH-1:0] a);
        logic [REQ_W-1:0] r;
        r = '0;
        r[REQ_DATA_LSB +: WIDTH]       = we ? data_of(a) : '0;
        r[REQ_ADDR_LSB +: ADDR_WIDTH]  = a;
        r[REQ_WE_BIT]                  = we;
        r[REQ_RE_BIT]                  = !we;
        r[REQ_SRC_LSB +: N_ADDR_WIDTH] = SRC_ID;
        return r;
    endfunction

    assign o_dest_out  = RAM_ID;
    assign i_ready_out = 1'b1;

    assign xfer     = o_valid_out && o_ready_in;
    assign last_idx = (idx == IDX_W'(NUM_WORDS - 1));

    // Responses are always accepted; only those matching an issued read pop
    assign rsp_data  = i_packed_in[RSP_DATA_LSB +: WIDTH];
    assign rsp_src   = i_packed_in[RSP_SRC_LSB +: N_ADDR_WIDTH];
    assign have_out  = !fifo_empty;
    assign fifo_pop  = i_valid_in && have_out;
    assign fifo_push = (state == READ) && xfer && (!fifo_full || fifo_pop);
    assign rsp_bad   = (rsp_data != data_of(exp_addr)) || (rsp_src != RAM_ID);
    assign rsp_err   = i_valid_in && (!have_out || rsp_bad);
    assign err_nxt   = rsp_err ? sat_inc(err_count) : err_count;
    assign rd_nxt    = fifo_pop ? sat_inc(rd_count) : rd_count;

    assign outstanding_nxt = outstanding + OUT_W'(fifo_push) - OUT_W'(fifo_pop);

    sync_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (ADDR_WIDTH)
    ) u_exp_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (o_packed_out[REQ_ADDR_LSB +: ADDR_WIDTH]),
        .dout  (exp_addr),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Run sequencing, registered request generation and result tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= '0;
            outstanding  <= '0;
            o_valid_out  <= 1'b0;
            o_packed_out <= '0;
            done         <= 1'b0;
            pass         <= 1'b0;
            err_count    <= '0;
            rd_count     <= '0;
        end else begin
            outstanding <= outstanding_nxt;
            err_count   <= err_nxt;
            rd_count    <= rd_nxt;
            case (state)
                WRITE: begin
                    if (xfer) begin
                        if (last_idx) begin
                            idx          <= '0;
                            state        <= READ;
                            o_valid_out  <= (outstanding_nxt < OUT_W'(MAX_OUTSTANDING));
                            o_packed_out <= pack_req(1'b0, addr_of('0));
                        end else begin
                            idx          <= idx + IDX_W'(1);
                            o_packed_out <= pack_req(1'b1, addr_of(idx + IDX_W'(1)));
                        end
                    end
                end
                READ: begin
                    if (xfer && last_idx) begin
                        idx          <= '0;
                        state        <= DRAIN;
                        o_valid_out  <= 1'b0;
                        o_packed_out <= '0;
                    end else begin
                        // Issue only while read credits remain
                        o_valid_out <= (outstanding_nxt < OUT_W'(MAX_OUTSTANDING));
                        if (xfer) begin
                            idx          <= idx + IDX_W'(1);
                            o_packed_out <= pack_req(1'b0, addr_of(idx + IDX_W'(1)));
                        end
                    end
                end
                DRAIN: begin
                    if (outstanding == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                        pass  <= (err_nxt == '0);
                    end
                end
                IDLE, DONE: begin
                    if (state == DONE) pass <= (err_nxt == '0);
                    if (start) begin
                        state        <= WRITE;
                        idx          <= '0;
                        done         <= 1'b0;
                        pass         <= 1'b0;
                        err_count    <= '0;
                        rd_count     <= '0;
                        o_valid_out  <= 1'b1;
                        o_packed_out <= pack_req(1'b1, addr_of('0));
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_requester.sv
// Bench for ram_requester: a RAM model answers the requests, a scoreboard
// of expected request words is filled at run start and drained on every
// accepted request, and run results are compared at completion.
`timescale 1ns/1ps
module tb_ram_requester;

    localparam int AW    = 4;
    localparam int REQ_W = 18;
    localparam int RSP_W = 12;

    typedef struct {
        int         due;
        logic [7:0] data;
    } rsp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start_a = 1'b0;
    logic             start_b = 1'b0;
    logic             o_ready_in = 1'b1;
    logic             i_valid_in = 1'b0;
    logic [RSP_W-1:0] i_packed_in = '0;
    logic             sel = 1'b0;

    logic [REQ_W-1:0] a_pkt, b_pkt;
    logic [3:0]       a_dest, b_dest;
    logic             a_valid, b_valid, a_rdy, b_rdy, a_done, b_done, a_pass, b_pass;
    logic [7:0]       a_err, b_err, a_rd, b_rd;

    logic [REQ_W-1:0] obs_pkt;
    logic             obs_valid, obs_done, obs_pass;
    logic [7:0]       obs_err, obs_rd;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    logic [REQ_W-1:0] exp_q[$];
    rsp_t       rsp_q[$];
    logic [7:0] mem [16];
    int         lat = 1;
    int         corrupt_n = 0;
    int         stall_at = -1;
    int         stall_left = 0;
    int         wr_seen = 0;
    int         rd_seen = 0;
    int         rd_at_first = -1;
    logic       spur = 1'b0;

    always #5 clk = ~clk;

    ram_requester dut_a (
        .clk (clk), .rst (rst), .start (start_a),
        .o_packed_out (a_pkt), .o_dest_out (a_dest), .o_valid_out (a_valid),
        .o_ready_in (o_ready_in), .i_packed_in (i_packed_in), .i_valid_in (i_valid_in),
        .i_ready_out (a_rdy), .done (a_done), .pass (a_pass),
        .err_count (a_err), .rd_count (a_rd)
    );

    ram_requester #(.BASE_ADDR(14), .NUM_WORDS(4)) dut_b (
        .clk (clk), .rst (rst), .start (start_b),
        .o_packed_out (b_pkt), .o_dest_out (b_dest), .o_valid_out (b_valid),
        .o_ready_in (o_ready_in), .i_packed_in (i_packed_in), .i_valid_in (i_valid_in),
        .i_ready_out (b_rdy), .done (b_done), .pass (b_pass),
        .err_count (b_err), .rd_count (b_rd)
    );

    assign obs_pkt   = sel ? b_pkt   : a_pkt;
    assign obs_valid = sel ? b_valid : a_valid;
    assign obs_done  = sel ? b_done  : a_done;
    assign obs_pass  = sel ? b_pass  : a_pass;
    assign obs_err   = sel ? b_err   : a_err;
    assign obs_rd    = sel ? b_rd    : a_rd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic load_expected(input int base, input int nw);
        logic [AW-1:0] a;
        logic [7:0]    d;
        for (int i = 0; i < nw; i++) begin
            a = AW'(base + i);
            d = 8'(a) + 8'h5A;
            exp_q.push_back({d, a, 1'b1, 1'b0, 4'd0});
        end
        for (int i = 0; i < nw; i++) begin
            a = AW'(base + i);
            exp_q.push_back({8'd0, a, 1'b0, 1'b1, 4'd0});
        end
    endtask

    // One clock: drive inputs and account for this edge's transfers at the
    // falling edge, then return 1ns after the rising edge.
    task automatic tick();
        logic [REQ_W-1:0] pkt;
        logic [AW-1:0]    a;
        logic [7:0]       d;
        rsp_t             r;
        @(negedge clk);
        cyc++;
        if (spur) begin
            i_valid_in  = 1'b1;
            i_packed_in = {8'h33, 4'd15};
            spur        = 1'b0;
        end else if (!rst && rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
            if (rd_at_first < 0) rd_at_first = rd_seen;
            i_valid_in  = 1'b1;
            i_packed_in = {rsp_q[0].data, 4'd15};
            void'(rsp_q.pop_front());
        end else begin
            i_valid_in  = 1'b0;
            i_packed_in = '0;
        end
        if (!rst && stall_at >= 0 && wr_seen == stall_at) begin
            stall_left = 5;
            stall_at   = -1;
        end
        o_ready_in = (stall_left == 0);
        if (stall_left > 0) begin
            stall_left--;
            check("stall_valid", obs_valid, 1);
            check("stall_pkt", obs_pkt, (exp_q.size() > 0) ? exp_q[0] : '1);
        end
        if (!rst && obs_valid && o_ready_in) begin
            pkt = obs_pkt;
            check("req_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) check("req_word", pkt, exp_q.pop_front());
            a = pkt[9:6];
            d = pkt[17:10];
            if (pkt[5]) begin
                mem[a] = d;
                wr_seen++;
            end else begin
                rd_seen++;
                d = mem[a];
                if (rd_seen == corrupt_n) d = d ^ 8'hFF;
                r.due  = cyc + lat;
                r.data = d;
                rsp_q.push_back(r);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic setup_run(input logic which, input int base, input int nw,
                             input int lat_i, input int corrupt_i, input int stall_i);
        sel = which; lat = lat_i; corrupt_n = corrupt_i; stall_at = stall_i;
        wr_seen = 0; rd_seen = 0; rd_at_first = -1;
        exp_q.delete();
        load_expected(base, nw);
        if (which) start_b = 1'b1; else start_a = 1'b1;
        tick();
        start_a = 1'b0; start_b = 1'b0;
        check("start_clears_done", obs_done, 0);
    endtask

    task automatic do_run(input logic which, input int base, input int nw, input int lat_i,
                          input int corrupt_i, input int stall_i, input int exp_err);
        int budget;
        setup_run(which, base, nw, lat_i, corrupt_i, stall_i);
        budget = 0;
        while (!obs_done && budget < 400) begin
            tick();
            budget++;
        end
        check("run_timeout", budget < 400, 1);
        check("sb_empty", exp_q.size(), 0);
        check("writes_seen", wr_seen, nw);
        check("reads_seen", rd_seen, nw);
        check("done", obs_done, 1);
        check("err_count", obs_err, exp_err);
        check("rd_count", obs_rd, nw);
        check("pass", obs_pass, exp_err == 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, a_valid, 0);
        check({tag, "_done"}, a_done, 0);
        check({tag, "_pass"}, a_pass, 0);
        check({tag, "_err"}, a_err, 0);
        check({tag, "_rd"}, a_rd, 0);
        check({tag, "_pkt"}, a_pkt, 0);
        check({tag, "_dest"}, a_dest, 15);
        check({tag, "_rdy"}, a_rdy, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int budget;
        int pending;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        check_reset_outputs("reset");
        check("reset_b_valid", b_valid, 0);

        // Plain loopback, then a corrupted 3rd read, then a mid-write stall
        do_run(1'b0, 0, 8, 1, 0, -1, 0);
        do_run(1'b0, 0, 8, 1, 3, -1, 1);
        do_run(1'b0, 0, 8, 1, 0, 3, 0);

        // Long response latency exercises the read credit limit
        do_run(1'b0, 0, 8, 20, 0, -1, 0);
        check("credit_limit", rd_at_first, 4);

        // Address wrap-around on the second instance
        do_run(1'b1, 14, 4, 1, 0, -1, 0);

        // Spurious response while idle
        sel = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        spur = 1'b1;
        tick();
        check("spur_err", a_err, 1);
        check("spur_rd", a_rd, 0);
        check("spur_valid", a_valid, 0);

        // Reset in the middle of the read phase with reads still in flight
        setup_run(1'b0, 0, 8, 20, 0, -1);
        budget = 0;
        while (rd_seen < 6 && budget < 300) begin
            tick();
            budget++;
        end
        check("midread_reached", rd_seen, 6);
        pending = rsp_q.size();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        check_reset_outputs("midrst");
        repeat (30) tick();
        check("inflight_err", a_err, pending);
        check("inflight_rd", a_rd, 0);
        check("inflight_valid", a_valid, 0);

        // Normal rerun after the aborted one
        do_run(1'b0, 0, 8, 1, 0, -1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_requester.md
RAM_REQUESTER -- requirements
Module: ram_requester

Interface
REQ-001 The module SHALL have the following parameters:
- WIDTH, 8: data word width.
- ADDR_WIDTH, 4: RAM address width.
- N, 16: number of NoC nodes.
- N_ADDR_WIDTH, $clog2(N): node-id width.
- NODE, 0: own node id.
- RAM_NODE, 15: node id of the RAM.
- BASE_ADDR, 0: first address of the test region.
- NUM_WORDS, 8: number of words to write, then read back.
- SEED, 8'h5A: data pattern offset.
- MAX_OUTSTANDING, 4: read credit limit.
REQ-002 Derived widths SHALL be REQ_W = WIDTH+ADDR_WIDTH+2+N_ADDR_WIDTH and RSP_W = WIDTH+N_ADDR_WIDTH.
REQ-003 The module SHALL have the following ports (clock and reset first):
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle pulse that begins a test run.
- o_packed_out  out  REQ_W  request, MSB-first {data, addr, write_en, read_en, src}.
- o_dest_out  out  N_ADDR_WIDTH  request destination; always RAM_NODE.
- o_valid_out  out  1  request valid.
- o_ready_in  in  1  network ready.
- i_packed_in  in  RSP_W  response, MSB-first {data, src_node}.
- i_valid_in  in  1  response valid.
- i_ready_out  out  1  response ready; constant 1.
- done  out  1  run complete.
- pass  out  1  done with zero errors.
- err_count  out  8  mismatch count, saturating.
- rd_count  out  8  responses received, saturating.

Function
REQ-004 The FSM SHALL have the states IDLE, WRITE, READ, DRAIN and DONE.
REQ-005 A start pulse in IDLE or DONE SHALL clear done, pass, err_count, rd_count and the index, and SHALL enter WRITE on the next cycle. A start pulse in any other state SHALL be ignored.
REQ-006 In WRITE, the module SHALL drive o_valid_out=1, write_en=1, read_en=0, addr=(BASE_ADDR+idx) mod 2^ADDR_WIDTH, data=(addr+SEED) mod 2^WIDTH and src=NODE.
REQ-007 A request SHALL transfer only on a cycle where o_valid_out and o_ready_in are both 1. While stalled, o_packed_out SHALL hold stable. idx SHALL increment on each transfer.
REQ-008 After transfer NUM_WORDS-1 in WRITE, the module SHALL reset idx to 0 and enter READ.
REQ-009 In READ, o_valid_out SHALL be 1 only while outstanding < MAX_OUTSTANDING. Read requests SHALL carry write_en=0, read_en=1, data=0, and addr as in REQ-006.
REQ-010 On each read transfer, the module SHALL push addr into the expected-address FIFO and increment outstanding. After transfer NUM_WORDS-1, it SHALL enter DRAIN.
REQ-011 On every cycle with i_valid_in=1, the module SHALL accept the response. If outstanding>0, it SHALL pop the FIFO, decrement outstanding, increment rd_count, and increment err_count if data != (popped addr+SEED) mod 2^WIDTH or src_node != RAM_NODE.
REQ-012 A response received with outstanding==0 SHALL increment err_count and SHALL NOT pop the FIFO.
REQ-013 When a read issue and a response occur in the same cycle, outstanding SHALL be unchanged. The FIFO SHALL support simultaneous push and pop, including when full or empty.
REQ-014 DRAIN SHALL go to DONE when outstanding==0. In DONE, done SHALL be 1 and pass SHALL be (err_count==0). Both SHALL be registered.
REQ-015 o_valid_out SHALL be 0 in IDLE, DRAIN and DONE.
REQ-016 Responses arriving while in IDLE or DONE SHALL be handled per REQ-012.

Reset
REQ-017 On rst, the FSM SHALL go to IDLE and o_valid_out, done, pass, err_count, rd_count, idx, outstanding and FIFO pointers SHALL all be 0.
REQ-018 On rst, o_packed_out SHALL be 0 and o_dest_out SHALL be RAM_NODE.
REQ-019 rst asserted mid-run SHALL abort the run. Responses still in flight SHALL then be handled per REQ-012 after reset.

Structure
REQ-020 The state enum and the request/response field offsets SHALL live in the shared package noc_ram_pkg.
REQ-021 The expected-address FIFO SHALL be a sub-module sync_fifo, with depth MAX_OUTSTANDING, width ADDR_WIDTH, and full/empty flags.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Loopback to the ram model, NUM_WORDS=8, ready tied 1 -> 8 writes at addresses 0..7 with data 5A..61, then 8 reads; done=1, pass=1, rd_count=8.
- Ram model corrupts the data of the 3rd read -> err_count=1, pass=0.
- o_ready_in held 0 for 5 cycles mid-WRITE -> o_packed_out stable while stalled; no write lost or duplicated.
- Response latency of 20 cycles -> at most 4 reads issued before the first response; the full run completes with pass=1.
- BASE_ADDR=14, NUM_WORDS=4 -> addresses 14, 15, 0, 1 (wrap-around); pass=1.
- Spurious response in IDLE, then rst pulsed mid-READ, then a normal run -> err_count=1 after the spurious response, all outputs 0 after rst, pass=1 after the rerun.
